// File: rtl/lvds_capture_sequencer.sv
// lvds_capture_sequencer: multi-packet capture sequencer for the LVDS ADC receiver.
// Issues start pulses, tracks packet completion, gaps, aborts and timeouts on ACLK.
module lvds_capture_sequencer #(
    parameter int CNT_W = 16,
    parameter int TO_W  = 24
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [31:0]      cfg_dsize,
    input  logic [CNT_W-1:0] cfg_npackets,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic             cfg_test,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic             rx_sr_pc,
    output logic             rx_start,
    output logic [31:0]      rx_dsize,
    output logic             rx_test,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             err_timeout,
    output logic             err_cfg
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        START,
        WAIT_ACK,
        WAIT_PC,
        GAP
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      dsize_q, dsize_d;
    logic             test_q, test_d;
    logic [CNT_W-1:0] npk_q, npk_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [TO_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic             abp_q, abp_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eto_q, eto_d;
    logic             ecfg_q, ecfg_d;

    logic             accept;
    logic             cfg_bad;
    logic             abort_any;
    logic             last_pkt;
    logic             to_hit;
    logic             gap_end;
    logic [CNT_W-1:0] pkt_inc;

    // Abort beats start when both arrive together in IDLE
    assign accept    = cmd_start && !cmd_abort;
    assign cfg_bad   = (cfg_dsize == '0);
    assign abort_any = abp_q || cmd_abort;
    assign pkt_inc   = (&pkt_q) ? pkt_q : pkt_q + 1'b1;
    assign last_pkt  = (npk_q != '0) && (pkt_inc == npk_q);
    assign to_hit    = (tmo_q != '0) && (tcnt_q == tmo_q - 1'b1);
    assign gap_end   = (gcnt_q == gap_q - 1'b1);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            dsize_q <= '0;
            test_q  <= 1'b0;
            npk_q   <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            gcnt_q  <= '0;
            tcnt_q  <= '0;
            pkt_q   <= '0;
            abp_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eto_q   <= 1'b0;
            ecfg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dsize_q <= dsize_d;
            test_q  <= test_d;
            npk_q   <= npk_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            gcnt_q  <= gcnt_d;
            tcnt_q  <= tcnt_d;
            pkt_q   <= pkt_d;
            abp_q   <= abp_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eto_q   <= eto_d;
            ecfg_q  <= ecfg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !cfg_bad) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (cmd_abort)     state_d = IDLE;
                else if (rx_sr_pc) state_d = START;
            end
            START: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Receiver still idle: the pulse was missed, send it again
                if (rx_sr_pc) state_d = START;
                else          state_d = WAIT_PC;
            end
            WAIT_PC: begin
                if (rx_sr_pc) begin
                    if (last_pkt || abort_any) state_d = IDLE;
                    else if (gap_q == '0)      state_d = WAIT_RDY;
                    else                       state_d = GAP;
                end else if (to_hit) begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cmd_abort)    state_d = IDLE;
                else if (gap_end) state_d = WAIT_RDY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dsize_d = dsize_q;
        test_d  = test_q;
        npk_d   = npk_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        pkt_d   = pkt_q;
        eto_d   = eto_q;
        ecfg_d  = ecfg_q;
        abp_d   = abp_q;
        gcnt_d  = '0;
        tcnt_d  = '0;
        start_d = (state_d == START);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q != IDLE) && (state_d == IDLE);

        if (state_q == IDLE) begin
            abp_d = 1'b0;
            if (accept) begin
                dsize_d = cfg_dsize;
                test_d  = cfg_test;
                npk_d   = cfg_npackets;
                gap_d   = cfg_gap;
                tmo_d   = cfg_timeout;
                pkt_d   = '0;
                eto_d   = 1'b0;
                ecfg_d  = cfg_bad;
                done_d  = cfg_bad;
            end
        end

        if ((state_q == START) || (state_q == WAIT_ACK)) begin
            if (cmd_abort) abp_d = 1'b1;
        end

        if (state_q == WAIT_PC) begin
            if (cmd_abort) abp_d = 1'b1;
            tcnt_d = tcnt_q + 1'b1;
            if (rx_sr_pc)    pkt_d = pkt_inc;
            else if (to_hit) eto_d = 1'b1;
        end

        if (state_q == GAP) begin
            gcnt_d = gcnt_q + 1'b1;
        end
    end

    assign rx_start    = start_q;
    assign rx_dsize    = dsize_q;
    assign rx_test     = test_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pkt_cnt     = pkt_q;
    assign err_timeout = eto_q;
    assign err_cfg     = ecfg_q;

endmodule
